// File: rtl/flappy_pkg.sv
// flappy_pkg: constants and types shared by the pipe generator, the
// renderer and the collision logic.
//   PIPE_X_W / GAP_Y_W : widths of a pipe column and a gap-top row
//   pipe_t             : one pipe slot {valid, x, gap_y}
package flappy_pkg;

  localparam int PIPE_X_W = 4;
  localparam int GAP_Y_W  = 4;

  typedef struct packed {
    logic                valid;
    logic [PIPE_X_W-1:0] x;
    logic [GAP_Y_W-1:0]  gap_y;
  } pipe_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; loads SEED
//   en    : advance one step this cycle; low holds the value
//   q     : current LFSR value
// SEED must be nonzero; the all-zero state locks up.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pipe_field_gen.sv
// pipe_field_gen: keeps up to NUM_PIPES scrolling pipes, spawns new ones at a
// fixed tick spacing, pulses pipe_passed when a pipe clears the bird column
// and shortens the scroll period as the level rises.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   playing     : advance enable; low freezes every register
//   pipe_x      : column per slot
//   gap_y       : gap top row per slot
//   pipe_valid  : slot occupied
//   pipe_passed : one-cycle score pulse
//   level       : difficulty level, saturates at 15
//   tick        : one-cycle scroll strobe
// X_W / Y_W must match the pipe_t field widths in flappy_pkg.
module pipe_field_gen
  import flappy_pkg::*;
#(
  parameter int          NUM_PIPES       = 3,
  parameter int          X_W             = PIPE_X_W,
  parameter int          Y_W             = GAP_Y_W,
  parameter int          FIELD_H         = 16,
  parameter int          GAP_SIZE        = 4,
  parameter int          BIRD_X          = 12,
  parameter int          SPACING         = 6,
  parameter int          TICK_INIT       = 10_000_000,
  parameter int          TICK_MIN        = 2_000_000,
  parameter int          TICK_STEP       = 1_000_000,
  parameter int          PIPES_PER_LEVEL = 5,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           playing,
  output logic [NUM_PIPES-1:0][X_W-1:0]  pipe_x,
  output logic [NUM_PIPES-1:0][Y_W-1:0]  gap_y,
  output logic [NUM_PIPES-1:0]           pipe_valid,
  output logic                           pipe_passed,
  output logic [3:0]                     level,
  output logic                           tick
);

  localparam int SP_W  = (SPACING > 1)         ? $clog2(SPACING)         : 1;
  localparam int PC_W  = (PIPES_PER_LEVEL > 1) ? $clog2(PIPES_PER_LEVEL) : 1;
  localparam int IDX_W = (NUM_PIPES > 1)       ? $clog2(NUM_PIPES)       : 1;

  localparam logic [SP_W-1:0]     SPAWN_LAST  = SP_W'(SPACING - 1);
  localparam logic [PC_W-1:0]     PASS_LAST   = PC_W'(PIPES_PER_LEVEL - 1);
  localparam logic [PIPE_X_W-1:0] X_LAST      = '1;
  localparam logic [PIPE_X_W-1:0] X_BIRD      = PIPE_X_W'(BIRD_X);
  localparam logic [7:0]          GAP_MOD     = 8'(FIELD_H - GAP_SIZE);
  localparam logic [31:0]         PERIOD_INIT = 32'(TICK_INIT);
  localparam logic [31:0]         PERIOD_MIN  = 32'(TICK_MIN);
  localparam logic [31:0]         PERIOD_STEP = 32'(TICK_STEP);

  pipe_t           slot_q [NUM_PIPES];
  pipe_t           slot_d [NUM_PIPES];
  logic [31:0]     period_q, period_d;
  logic [31:0]     tick_cnt_q, tick_cnt_d;
  logic [SP_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [PC_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [3:0]      level_q, level_d;
  logic            pipe_passed_q, pipe_passed_d;

  logic [15:0]      lfsr;
  logic             tick_now;
  logic             pass_hit;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             spawn_now;
  logic [7:0]       spawn_gap;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (playing),
    .q     (lfsr)
  );

  always_comb begin
    // >= rather than == keeps the counter safe if the period ever shrinks
    // below the running count.
    tick_now   = playing && (tick_cnt_q >= period_q - 32'd1);
    tick_cnt_d = tick_cnt_q;
    if (playing) tick_cnt_d = tick_now ? 32'd0 : tick_cnt_q + 32'd1;

    // Lowest-index free slot, taken from the pre-tick occupancy so a slot
    // vacated on this tick is not reused until the next one.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    spawn_gap   = lfsr[7:0] % GAP_MOD;
    spawn_now   = tick_now && (spawn_cnt_q == SPAWN_LAST) && free_found;
    spawn_cnt_d = spawn_cnt_q;
    if (tick_now) begin
      if (spawn_now)                       spawn_cnt_d = '0;
      else if (spawn_cnt_q != SPAWN_LAST) spawn_cnt_d = spawn_cnt_q + SP_W'(1);
    end

    pass_hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      slot_d[i] = slot_q[i];
      if (tick_now && slot_q[i].valid) begin
        if (slot_q[i].x == X_BIRD) pass_hit = 1'b1;
        if (slot_q[i].x == X_LAST) slot_d[i].valid = 1'b0;
        else                       slot_d[i].x     = slot_q[i].x + PIPE_X_W'(1);
      end
      if (spawn_now && free_idx == IDX_W'(i)) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].x     = '0;
        slot_d[i].gap_y = GAP_Y_W'(spawn_gap);
      end
    end

    // A pulse raised just before a pause is held and delivered on resume.
    pipe_passed_d = playing ? (tick_now && pass_hit) : pipe_passed_q;

    pass_cnt_d = pass_cnt_q;
    level_d    = level_q;
    period_d   = period_q;
    if (playing && pipe_passed_q) begin
      if (pass_cnt_q == PASS_LAST) begin
        pass_cnt_d = '0;
        if (level_q != 4'hF) level_d = level_q + 4'd1;
        period_d = (period_q >= PERIOD_MIN + PERIOD_STEP) ? period_q - PERIOD_STEP
                                                          : PERIOD_MIN;
      end else begin
        pass_cnt_d = pass_cnt_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) slot_q[i] <= '0;
      period_q      <= PERIOD_INIT;
      tick_cnt_q    <= '0;
      spawn_cnt_q   <= SPAWN_LAST;
      pass_cnt_q    <= '0;
      level_q       <= '0;
      pipe_passed_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PIPES; i++) slot_q[i] <= slot_d[i];
      period_q      <= period_d;
      tick_cnt_q    <= tick_cnt_d;
      spawn_cnt_q   <= spawn_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      level_q       <= level_d;
      pipe_passed_q <= pipe_passed_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[i]     = X_W'(slot_q[i].x);
      gap_y[i]      = Y_W'(slot_q[i].gap_y);
      pipe_valid[i] = slot_q[i].valid;
    end
  end

  assign tick        = tick_now;
  assign pipe_passed = pipe_passed_q && playing;
  assign level       = level_q;

endmodule
